aes_wb_multi_bridge: RTL and testbench
======================================

// Module: aes_wb_multi_bridge
// PURPOSE
// Wishbone slave front-end for NUM_CH independent AES core channels on one bus segment.
// - Decodes a page field into a per-channel core select.
// - Sequences core accesses through a response FSM with configurable read latency.
// - Flags unmapped or illegal accesses with err_o.
// - Collects per-channel ready edges into a maskable, write-1-to-clear interrupt.
// PARAMETERS
// NUM_CH   2   number of AES channels, 1..8
// CORE_AW  8   core word-address width; core address = wbs_adr_i[CORE_AW+1:2]
// RD_LAT   0   core read-data latency in cycles after cs, 0..3
// PORTS
// wb_clk_i     in   1           single clock for the bus and all channels
// wb_rst_n     in   1           synchronous reset, active low
// wbs_stb_i    in   1           Wishbone strobe
// wbs_cyc_i    in   1           Wishbone cycle
// wbs_we_i     in   1           Wishbone write enable
// wbs_sel_i    in   4           byte selects
// wbs_adr_i    in   32          byte address
// wbs_dat_i    in   32          write data
// wbs_ack_o    out  1           access acknowledge, one-cycle pulse
// wbs_err_o    out  1           error termination, one-cycle pulse
// wbs_dat_o    out  32          read data, valid while ack is high
// ch_cs_o      out  NUM_CH      one-hot core chip select
// ch_we_o      out  1           core write enable, qualified by ch_cs_o
// ch_addr_o    out  CORE_AW     core word address
// ch_wdata_o   out  32          core write data
// ch_rdata_i   in   NUM_CH*32   core read data; channel k occupies bits [32k+31:32k]
// ch_ready_i   in   NUM_CH      core ready/valid status level per channel
// irq_o        out  1           registered interrupt: |(irq_status & irq_enable)
// BEHAVIOUR
// - Clock and reset: wb_clk_i only; reset is synchronous and active-low on wb_rst_n.
// - Reset values: ack/err/irq_o = 0, dat_o = 0, ch_cs_o = 0, ch_we_o = 0.
//   irq_status = 0, irq_enable = 0, FSM = IDLE.
// - Page decode: page = wbs_adr_i[CORE_AW+5:CORE_AW+2].
//   - page < NUM_CH: channel access.
//   - page == 4'hF: control page.
//   - Any other page: unmapped.
// - Control page: offset 0x00 IRQ_STATUS (R/W1C), 0x04 IRQ_ENABLE (RW).
//   0x08 ID (RO) = {16'h0, RD_LAT[3:0], CORE_AW[3:0], NUM_CH[7:0]}.
//   Other offsets read 0; writes to them are ignored.
// - FSM states: IDLE, ACCESS, WAIT, RESP.
//   - IDLE: stb&cyc sampled at edge T -> ACCESS.
//   - ACCESS (cycle T+1): for a legal channel access, ch_cs_o[page] = 1 and ch_we_o = wbs_we_i.
//     Then -> RESP for a write, or when RD_LAT == 0; else -> WAIT.
//   - WAIT: counts RD_LAT-1 further cycles, then -> RESP.
//   - RESP: ack or err high for exactly one cycle -> IDLE. Back-to-back requests resume from IDLE.
// - Response timing: writes and control reads ack at T+2; channel reads ack at T+2+RD_LAT.
// - Read data capture: ch_rdata_i of the addressed channel is registered on the cycle before RESP.
//   dat_o holds its value until the next capture.
// - Data paths: ch_addr_o and ch_wdata_o are combinational from wbs_adr_i/wbs_dat_i.
//   The master holds them stable until ack.
// - Errors: an unmapped page, or a channel write with sel != 4'hF, gives err_o at T+2.
//   No cs is asserted and no state changes.
// - Control page ignores sel.
// - Abort: if cyc_i is low in ACCESS, WAIT or RESP, the FSM returns to IDLE next cycle.
//   No ack/err is issued. A core write already issued is not undone.
// - Reset mid-access: the FSM returns to IDLE, outputs take their reset values, and no response is issued.
// - IRQ: ready_q <= ch_ready_i; a rising edge of ch_ready_i[k] sets irq_status[k].
//   A W1C write clears the bits where dat_i = 1. If set and clear hit the same bit in the same cycle, set wins.
//   irq_o is registered, one cycle after a status or enable change.
// - Width: unused upper bits of irq_status/enable (bits >= NUM_CH) read 0.
// STRUCTURE
// - Package aes_wb_pkg: state enum, control page code 4'hF, control offsets, ID layout.
// - Sub-module aes_wb_irq_ctrl: edge detect, status/enable registers, W1C, irq_o.
// - Top: decode, FSM, latency counter, read mux/capture.
// TESTING
// - Write ch1 addr 0x10 = 0xDEADBEEF, sel=F -> ch_cs_o=2'b10, ch_we_o=1 at T+1.
//   ch_wdata_o = DEADBEEF, ack at T+2, ch0 untouched.
// - RD_LAT=2 read ch0 with ch_rdata_i[31:0] = 0x12345678 -> cs at T+1, ack at T+4, dat_o = 0x12345678.
// - Read page 0x5 with NUM_CH=2 -> err at T+2, no ack, ch_cs_o stays 0.
//   Channel write with sel=4'h3 -> err, no cs.
// - Raise ch_ready_i[0] with IRQ_ENABLE=1 -> irq_status=1, irq_o high 2 cycles after the edge.
//   W1C 0x1 in the same cycle as a new edge -> bit stays set.
// - Drop cyc in WAIT (RD_LAT=3) -> no ack, FSM back in IDLE.
//   The following write acks normally at T+2.
// - Assert wb_rst_n=0 during WAIT -> ack=0, ch_cs_o=0, irq regs cleared next edge.
//   ID read after reset returns {RD_LAT, CORE_AW, NUM_CH}.

Source files
------------

// File: rtl/aes_wb_pkg.sv
// Shared types and constants for the multi-channel AES Wishbone bridge:
// FSM state encoding, control-page decode values and the ID word layout.
package aes_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [3:0] CTRL_PAGE = 4'hF;

    // Control-page registers as word indices (byte offset / 4)
    localparam int CTRL_W_STATUS = 0;
    localparam int CTRL_W_ENABLE = 1;
    localparam int CTRL_W_ID     = 2;

    function automatic logic [31:0] make_id(input int num_ch, input int core_aw, input int rd_lat);
        return {16'h0, rd_lat[3:0], core_aw[3:0], num_ch[7:0]};
    endfunction

endpackage

// File: rtl/aes_wb_irq_ctrl.sv
// Per-channel ready edge detection feeding a W1C status register, a
// read/write enable mask and the registered interrupt output.
module aes_wb_irq_ctrl
    import aes_wb_pkg::*;
#(
    parameter int NUM_CH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ready_i,
    input  logic              clr_we_i,
    input  logic              en_we_i,
    input  logic [NUM_CH-1:0] wdata_i,
    output logic [NUM_CH-1:0] status_o,
    output logic [NUM_CH-1:0] enable_o,
    output logic              irq_o
);

    logic [NUM_CH-1:0] ready_q, ready_d;
    logic [NUM_CH-1:0] status_q, status_d;
    logic [NUM_CH-1:0] enable_q, enable_d;
    logic              irq_q, irq_d;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] clr_mask;

    always_comb begin
        rise     = ready_i & ~ready_q;
        clr_mask = clr_we_i ? wdata_i : '0;
        ready_d  = ready_i;
        // A new edge in the same cycle as a clear keeps the bit set
        status_d = (status_q & ~clr_mask) | rise;
        enable_d = en_we_i ? wdata_i : enable_q;
        irq_d    = |(status_q & enable_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_q  <= '0;
            status_q <= '0;
            enable_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            ready_q  <= ready_d;
            status_q <= status_d;
            enable_q <= enable_d;
            irq_q    <= irq_d;
        end
    end

    assign status_o = status_q;
    assign enable_o = enable_q;
    assign irq_o    = irq_q;

endmodule

// File: rtl/aes_wb_multi_bridge.sv
// Wishbone slave front-end for NUM_CH AES cores: page decode, response FSM
// with configurable core read latency, read capture and control page.
module aes_wb_multi_bridge
    import aes_wb_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int CORE_AW = 8,
    parameter int RD_LAT  = 0
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_we_i,
    input  logic [3:0]           wbs_sel_i,
    input  logic [31:0]          wbs_adr_i,
    input  logic [31:0]          wbs_dat_i,
    output logic                 wbs_ack_o,
    output logic                 wbs_err_o,
    output logic [31:0]          wbs_dat_o,
    output logic [NUM_CH-1:0]    ch_cs_o,
    output logic                 ch_we_o,
    output logic [CORE_AW-1:0]   ch_addr_o,
    output logic [31:0]          ch_wdata_o,
    input  logic [NUM_CH*32-1:0] ch_rdata_i,
    input  logic [NUM_CH-1:0]    ch_ready_i,
    output logic                 irq_o
);

    localparam logic [4:0] NUM_CH_L = 5'(NUM_CH);

    state_t            state_q, state_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [31:0]       dat_q, dat_d;
    logic [NUM_CH-1:0] cs_q, cs_d;
    logic              we_q, we_d;
    logic [1:0]        lat_q, lat_d;

    logic [3:0]        page;
    logic              is_chan, is_ctrl, bad;
    logic [NUM_CH-1:0] page_onehot;
    logic [31:0]       rdata_sel, ctrl_rdata;
    logic              wr_status, wr_enable;
    logic [NUM_CH-1:0] irq_status, irq_enable;
    logic              unused_bits;

    assign page        = wbs_adr_i[CORE_AW+5:CORE_AW+2];
    assign ch_addr_o   = wbs_adr_i[CORE_AW+1:2];
    assign ch_wdata_o  = wbs_dat_i;
    assign unused_bits = &{1'b0, wbs_adr_i[31:CORE_AW+6], wbs_adr_i[1:0]};

    always_comb begin
        is_chan     = ({1'b0, page} < NUM_CH_L);
        is_ctrl     = (page == CTRL_PAGE);
        bad         = (!is_chan && !is_ctrl) || (is_chan && wbs_we_i && wbs_sel_i != 4'hF);
        page_onehot = NUM_CH'(1) << page;
        rdata_sel   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (page == 4'(k)) rdata_sel = ch_rdata_i[32*k +: 32];
        end
        if (ch_addr_o == CORE_AW'(CTRL_W_STATUS))      ctrl_rdata = {{(32-NUM_CH){1'b0}}, irq_status};
        else if (ch_addr_o == CORE_AW'(CTRL_W_ENABLE)) ctrl_rdata = {{(32-NUM_CH){1'b0}}, irq_enable};
        else if (ch_addr_o == CORE_AW'(CTRL_W_ID))     ctrl_rdata = make_id(NUM_CH, CORE_AW, RD_LAT);
        else                                           ctrl_rdata = '0;
    end

    always_comb begin
        state_d   = state_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        dat_d     = dat_q;
        cs_d      = '0;
        we_d      = 1'b0;
        lat_d     = lat_q;
        wr_status = 1'b0;
        wr_enable = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wbs_stb_i && wbs_cyc_i) begin
                    state_d = ST_ACCESS;
                    if (is_chan && !bad) begin
                        cs_d = page_onehot;
                        we_d = wbs_we_i;
                    end
                end
            end
            ST_ACCESS: begin
                if (!wbs_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (bad) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                end else if (wbs_we_i || is_ctrl || RD_LAT == 0) begin
                    state_d   = ST_RESP;
                    ack_d     = 1'b1;
                    wr_status = wbs_we_i && is_ctrl && ch_addr_o == CORE_AW'(CTRL_W_STATUS);
                    wr_enable = wbs_we_i && is_ctrl && ch_addr_o == CORE_AW'(CTRL_W_ENABLE);
                    if (!wbs_we_i) dat_d = is_ctrl ? ctrl_rdata : rdata_sel;
                end else begin
                    state_d = ST_WAIT;
                    lat_d   = 2'(RD_LAT - 1);
                end
            end
            ST_WAIT: begin
                // Stays RD_LAT cycles so capture lands when core data is valid
                if (!wbs_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (lat_q == 2'd0) begin
                    state_d = ST_RESP;
                    ack_d   = 1'b1;
                    dat_d   = rdata_sel;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
            cs_q    <= '0;
            we_q    <= 1'b0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
            lat_q   <= lat_d;
        end
    end

    // A master that drops cyc during the response cycle sees no termination
    assign wbs_ack_o = ack_q & wbs_cyc_i;
    assign wbs_err_o = err_q & wbs_cyc_i;
    assign wbs_dat_o = dat_q;
    assign ch_cs_o   = cs_q;
    assign ch_we_o   = we_q;

    aes_wb_irq_ctrl #(.NUM_CH(NUM_CH)) u_irq (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_n),
        .ready_i  (ch_ready_i),
        .clr_we_i (wr_status),
        .en_we_i  (wr_enable),
        .wdata_i  (wbs_dat_i[NUM_CH-1:0]),
        .status_o (irq_status),
        .enable_o (irq_enable),
        .irq_o    (irq_o)
    );

endmodule

// File: tb/tb_aes_wb_multi_bridge.sv
// Scoreboard bench for aes_wb_multi_bridge: driver pushes expected responses,
// a monitor pops and compares them against a behavioural core/register model.
module tb_aes_wb_multi_bridge;

    localparam int NUM_CH  = 2;
    localparam int CORE_AW = 8;
    localparam int RD_LAT  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]           sel = 4'h0;
    logic [31:0]          adr = '0, dat_i = '0;
    logic                 ack, err, irq;
    logic [31:0]          dat_o;
    logic [NUM_CH-1:0]    ch_cs;
    logic                 ch_we;
    logic [CORE_AW-1:0]   ch_addr;
    logic [31:0]          ch_wdata;
    logic [NUM_CH*32-1:0] ch_rdata;
    logic [NUM_CH-1:0]    ch_ready = '0;

    aes_wb_multi_bridge #(.NUM_CH(NUM_CH), .CORE_AW(CORE_AW), .RD_LAT(RD_LAT)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n   (rst_n),
        .wbs_stb_i  (stb),
        .wbs_cyc_i  (cyc),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (dat_i),
        .wbs_ack_o  (ack),
        .wbs_err_o  (err),
        .wbs_dat_o  (dat_o),
        .ch_cs_o    (ch_cs),
        .ch_we_o    (ch_we),
        .ch_addr_o  (ch_addr),
        .ch_wdata_o (ch_wdata),
        .ch_rdata_i (ch_rdata),
        .ch_ready_i (ch_ready),
        .irq_o      (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc_cnt);
        end
    endtask

    // Behavioural AES core stand-in: word memory, read data valid RD_LAT cycles after cs
    function automatic logic [31:0] init_pat(input int k, input int a);
        return 32'hC0DE_0000 | (32'(k) << 12) | 32'(a);
    endfunction

    logic [31:0] core_mem [NUM_CH][256];
    int          age [NUM_CH];
    logic        core_init = 1'b1;

    always @(posedge clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (core_init) begin
                for (int a = 0; a < 256; a++) core_mem[k][a] <= init_pat(k, a);
                age[k] <= 0;
            end else begin
                if (ch_cs[k] && ch_we) core_mem[k][ch_addr] <= ch_wdata;
                if (ch_cs[k] && !ch_we) age[k] <= 1;
                else if (age[k] > 0 && age[k] < 8) age[k] <= age[k] + 1;
            end
        end
    end

    always_comb begin
        ch_rdata = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if ((RD_LAT == 0 && ch_cs[k] && !ch_we) || (RD_LAT > 0 && age[k] == RD_LAT))
                ch_rdata[32*k +: 32] = core_mem[k][ch_addr];
            else
                ch_rdata[32*k +: 32] = 32'hBAD0_BAD0;
        end
    end

    // Reference model state
    logic [31:0] ref_mem [NUM_CH][256];
    logic [NUM_CH-1:0] ref_status = '0;
    logic [NUM_CH-1:0] ref_enable = '0;
    localparam logic [31:0] EXP_ID = {16'h0, 4'(RD_LAT), 4'(CORE_AW), 8'(NUM_CH)};

    typedef struct {
        logic        is_err;
        logic        chk_dat;
        logic [31:0] dat;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (ack || err) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL resp_unexpected: got ack=%0b err=%0b want no response (cycle %0d)", ack, err, cyc_cnt);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_kind", {30'd0, ack, err}, mon_e.is_err ? 32'd1 : 32'd2);
                chk("resp_cycle", 32'(cyc_cnt), 32'(mon_e.cyc));
                if (mon_e.chk_dat) chk("resp_data", dat_o, mon_e.dat);
            end
        end
    end

    function automatic logic [31:0] adr_of(input int page, input int word);
        return (32'(page) << (CORE_AW + 2)) | (32'(word) << 2);
    endfunction

    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic exp_err, input logic [31:0] exp_dat, input logic chk_dat,
                          input int lat, input logic [NUM_CH-1:0] exp_cs, input logic raise0);
        exp_t e;
        logic got;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        e.is_err = exp_err; e.chk_dat = chk_dat; e.dat = exp_dat; e.cyc = cyc_cnt + 2 + lat;
        sb.push_back(e);
        @(negedge clk);
        chk("ch_cs", 32'(ch_cs), 32'(exp_cs));
        if (exp_cs != '0) begin
            chk("ch_we", 32'(ch_we), 32'(w));
            chk("ch_addr", 32'(ch_addr), 32'(a[CORE_AW+1:2]));
            if (w) chk("ch_wdata", ch_wdata, d);
        end
        if (raise0) ch_ready[0] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            got = ack | err;
        end
        if (!got) chk("resp_timeout", 32'd0, 32'd1);
        #1;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(negedge clk);
        chk("irq_o", {31'd0, irq}, {31'd0, |(ref_status & ref_enable)});
    endtask

    task automatic ch_write(input int ch, input int word, input logic [31:0] d);
        ref_mem[ch][word] = d;
        do_req(1'b1, adr_of(ch, word), d, 4'hF, 1'b0, 32'd0, 1'b0, 0, NUM_CH'(1 << ch), 1'b0);
    endtask

    task automatic ch_read(input int ch, input int word);
        do_req(1'b0, adr_of(ch, word), $urandom, 4'($urandom_range(15, 0)), 1'b0, ref_mem[ch][word],
               1'b1, RD_LAT, NUM_CH'(1 << ch), 1'b0);
    endtask

    task automatic ctrl_write(input int word, input logic [31:0] d, input logic raise0);
        if (word == 0) ref_status = (ref_status & ~d[NUM_CH-1:0]) | {{(NUM_CH-1){1'b0}}, raise0};
        else if (word == 1) ref_enable = d[NUM_CH-1:0];
        do_req(1'b1, adr_of(15, word), d, 4'($urandom_range(15, 0)), 1'b0, 32'd0, 1'b0, 0, '0, raise0);
    endtask

    task automatic ctrl_read(input int word);
        logic [31:0] x;
        if (word == 0)      x = 32'(ref_status);
        else if (word == 1) x = 32'(ref_enable);
        else if (word == 2) x = EXP_ID;
        else                x = 32'd0;
        do_req(1'b0, adr_of(15, word), $urandom, 4'($urandom_range(15, 0)), 1'b0, x, 1'b1, 0, '0, 1'b0);
    endtask

    task automatic bad_req(input int page, input logic w, input int word, input logic [3:0] s);
        do_req(w, adr_of(page, word), $urandom, s, 1'b1, 32'd0, 1'b0, 0, '0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NUM_CH; k++)
            for (int a = 0; a < 256; a++) ref_mem[k][a] = init_pat(k, a);
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_cs", 32'(ch_cs), 32'd0);
        chk("rst_we", {31'd0, ch_we}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;
        core_init = 1'b0;

        ctrl_read(2);
        ch_write(1, 4, 32'hDEADBEEF);
        ch_read(1, 4);
        ch_read(0, 4);
        ch_write(0, 0, 32'h12345678);
        ch_read(0, 0);

        bad_req(5, 1'b0, 0, 4'hF);
        bad_req(0, 1'b1, 7, 4'h3);
        ch_read(0, 7);

        ctrl_write(1, 32'h1, 1'b0);
        @(negedge clk);
        ch_ready[0] = 1'b1;
        ref_status[0] = 1'b1;
        @(negedge clk);
        chk("irq_lag", {31'd0, irq}, 32'd0);
        @(negedge clk);
        chk("irq_rise", {31'd0, irq}, 32'd1);
        ctrl_read(0);
        ch_ready[0] = 1'b0;
        repeat (2) @(negedge clk);
        ctrl_write(0, 32'h1, 1'b1);
        ctrl_read(0);
        ctrl_write(0, 32'h1, 1'b0);
        ctrl_read(0);
        ctrl_read(3);

        // Abort a channel read in its wait phase
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = adr_of(0, 9); sel = 4'hF;
        repeat (2) @(negedge clk);
        stb = 1'b0; cyc = 1'b0;
        repeat (6) @(negedge clk);
        ch_write(0, 9, 32'hA5A5_0009);
        ch_read(0, 9);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(6, 0))
                0: ch_write($urandom_range(NUM_CH-1, 0), $urandom_range(255, 0), $urandom);
                1: ch_read($urandom_range(NUM_CH-1, 0), $urandom_range(255, 0));
                2: bad_req($urandom_range(14, NUM_CH), $urandom_range(1, 0) == 1, $urandom_range(255, 0), 4'hF);
                3: bad_req($urandom_range(NUM_CH-1, 0), 1'b1, $urandom_range(255, 0), 4'($urandom_range(14, 0)));
                4: ctrl_write($urandom_range(3, 0), $urandom, 1'b0);
                5: ctrl_read($urandom_range(4, 0));
                default: ch_read($urandom_range(NUM_CH-1, 0), $urandom_range(3, 0));
            endcase
        end

        // Reset in the middle of a channel read with the interrupt asserted
        ctrl_write(1, 32'h3, 1'b0);
        @(negedge clk);
        ch_ready[1] = 1'b1;
        ref_status[1] = 1'b1;
        repeat (3) @(negedge clk);
        chk("irq_pre_rst", {31'd0, irq}, 32'd1);
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = adr_of(1, 4); sel = 4'hF;
        repeat (2) @(negedge clk);
        rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; ch_ready = '0;
        @(negedge clk);
        chk("mid_rst_ack", {31'd0, ack}, 32'd0);
        chk("mid_rst_cs", 32'(ch_cs), 32'd0);
        chk("mid_rst_irq", {31'd0, irq}, 32'd0);
        chk("mid_rst_dat", dat_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ref_status = '0;
        ref_enable = '0;
        ctrl_read(2);
        ctrl_read(0);
        ctrl_read(1);
        ch_read(1, 4);

        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
